temp_poll_ctrl: RTL and testbench

- Periodic sampling controller for the temperature path.
- Polls the sensor read interface over a req/ack handshake on a fixed interval, and holds the captured 16-bit word stable for the BCD/zone converter.
- Classifies each sample into the Frio/Normal/Quente zones and filters the classification with an N-consecutive-sample confirmation so the LCD selection does not flicker at thresholds.
- Flags sensor read timeouts.

---
 rtl/temp_pkg.sv | 40 ++++
 rtl/temp_poll_ctrl_if.sv | 11 +
 rtl/poll_timer.sv | 26 ++
 rtl/temp_poll_ctrl.sv | 159 +++++++++++++++
 tb/tb_temp_poll_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/temp_pkg.sv
// Shared types and constants for the temperature polling path.
package temp_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ZONE_W = 2;
  localparam int unsigned HALF_W = 7;

  // Half-degree thresholds: <=32.0 C is cold, >=35.5 C is hot.
  localparam logic [HALF_W-1:0] COLD_MAX_HALF = 7'd64;
  localparam logic [HALF_W-1:0] HOT_MIN_HALF  = 7'd71;

  typedef enum logic [ZONE_W-1:0] {
    ZONE_FRIO   = 2'd0,
    ZONE_NORMAL = 2'd1,
    ZONE_QUENTE = 2'd2
  } zone_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    CAPTURE = 2'd2,
    ERR     = 2'd3
  } state_e;

  // Sensor word layout: integer degrees in [13:8], +0.5 C flag in [7].
  typedef struct packed {
    logic [1:0] rsvd;
    logic [5:0] deg_c;
    logic       half_c;
    logic [6:0] frac_lo;
  } sensor_word_t;

  // Map a half-degree value to its zone.
  function automatic zone_e classify_half(input logic [HALF_W-1:0] h);
    if (h <= COLD_MAX_HALF)     return ZONE_FRIO;
    else if (h >= HOT_MIN_HALF) return ZONE_QUENTE;
    else                        return ZONE_NORMAL;
  endfunction

endpackage

// File: rtl/temp_poll_ctrl_if.sv
// Sensor read handshake: controller raises rd_req, reader answers with rd_ack + rd_data.
interface temp_poll_ctrl_if;

  logic                  rd_req;
  logic                  rd_ack;
  temp_pkg::sensor_word_t rd_data;

  modport master (output rd_req, input rd_ack, input rd_data);
  modport slave  (input rd_req, output rd_ack, output rd_data);

endinterface

// File: rtl/poll_timer.sv
// Free-running poll interval counter; tick lasts one cycle every POLL_DIV cycles.
module poll_timer #(
  parameter int unsigned POLL_DIV = 50000000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_enable,
  output logic o_tick_c
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap   = (r_cnt == CNT_W'(POLL_DIV - 1));
  assign o_tick_c = i_enable & w_wrap;

  // Count while enabled, wrap at the interval end, hold at zero when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_cnt <= '0;
    else if (!i_enable) r_cnt <= '0;
    else if (w_wrap)    r_cnt <= '0;
    else                r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/temp_poll_ctrl.sv
// Periodic sensor poll with capture, zone classification and N-sample zone confirmation.
module temp_poll_ctrl
  import temp_pkg::*;
#(
  parameter int unsigned POLL_DIV = 50000000,
  parameter int unsigned TIMEOUT  = 1000000,
  parameter int unsigned CONFIRM  = 3,
  parameter int unsigned CNT_W    = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  temp_poll_ctrl_if.master  rd,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [ZONE_W-1:0] zone_out,
  output logic              zone_valid,
  output logic              err_timeout,
  output logic [7:0]        sample_cnt
);

  localparam int unsigned FCNT_W = $clog2(CONFIRM + 1);

  state_e             r_state,      w_state;
  logic               r_rd_req,     w_rd_req;
  logic [CNT_W-1:0]   r_tcnt,       w_tcnt;
  sensor_word_t       r_word,       w_word;
  logic [DATA_W-1:0]  r_data_out,   w_data_out;
  logic               r_data_valid, w_data_valid;
  logic [7:0]         r_sample_cnt, w_sample_cnt;
  logic               r_err,        w_err;
  zone_e              r_zone,       w_zone;
  logic               r_zone_valid, w_zone_valid;
  zone_e              r_cand,       w_cand;
  logic [FCNT_W-1:0]  r_fcnt,       w_fcnt;
  logic [FCNT_W-1:0]  w_fcnt_tmp;
  zone_e              w_raw;
  logic               w_tick_c;

  poll_timer #(
    .POLL_DIV (POLL_DIV),
    .CNT_W    (CNT_W)
  ) u_poll_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (enable),
    .o_tick_c (w_tick_c)
  );

  assign rd.rd_req   = r_rd_req;
  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign zone_out    = r_zone;
  assign zone_valid  = r_zone_valid;
  assign err_timeout = r_err;
  assign sample_cnt  = r_sample_cnt;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rd_req     <= 1'b0;
      r_tcnt       <= '0;
      r_word       <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_sample_cnt <= '0;
      r_err        <= 1'b0;
      r_zone       <= ZONE_FRIO;
      r_zone_valid <= 1'b0;
      r_cand       <= ZONE_FRIO;
      r_fcnt       <= '0;
    end else begin
      r_state      <= w_state;
      r_rd_req     <= w_rd_req;
      r_tcnt       <= w_tcnt;
      r_word       <= w_word;
      r_data_out   <= w_data_out;
      r_data_valid <= w_data_valid;
      r_sample_cnt <= w_sample_cnt;
      r_err        <= w_err;
      r_zone       <= w_zone;
      r_zone_valid <= w_zone_valid;
      r_cand       <= w_cand;
      r_fcnt       <= w_fcnt;
    end
  end

  // Next-state, handshake, capture and zone filter.
  always_comb begin
    w_state      = r_state;
    w_rd_req     = 1'b0;
    w_tcnt       = '0;
    w_word       = r_word;
    w_data_out   = r_data_out;
    w_data_valid = 1'b0;
    w_sample_cnt = r_sample_cnt;
    w_err        = r_err;
    w_zone       = r_zone;
    w_zone_valid = r_zone_valid;
    w_cand       = r_cand;
    w_fcnt       = r_fcnt;
    w_fcnt_tmp   = r_fcnt;
    w_raw        = classify_half({r_word.deg_c, r_word.half_c});

    case (r_state)
      IDLE: begin
        if (w_tick_c) begin
          w_state  = REQ;
          w_rd_req = 1'b1;
        end
      end
      REQ: begin
        w_tcnt = r_tcnt + CNT_W'(1);
        if (rd.rd_ack) begin
          w_state = CAPTURE;
          w_word  = rd.rd_data;
        end else if (r_tcnt == CNT_W'(TIMEOUT - 1)) begin
          w_state = ERR;
        end else begin
          w_rd_req = 1'b1;
        end
      end
      CAPTURE: begin
        w_data_out   = r_word;
        w_data_valid = 1'b1;
        w_sample_cnt = r_sample_cnt + 8'd1;
        w_err        = 1'b0;
        if (!r_zone_valid) begin
          w_zone       = w_raw;
          w_zone_valid = 1'b1;
          w_fcnt       = '0;
        end else begin
          if (w_raw == r_zone) begin
            w_fcnt_tmp = '0;
          end else if (w_raw == r_cand) begin
            w_fcnt_tmp = r_fcnt + FCNT_W'(1);
          end else begin
            w_cand     = w_raw;
            w_fcnt_tmp = FCNT_W'(1);
          end
          if (w_fcnt_tmp == FCNT_W'(CONFIRM)) begin
            w_zone = w_cand;
            w_fcnt = '0;
          end else begin
            w_fcnt = w_fcnt_tmp;
          end
        end
        w_state = IDLE;
      end
      ERR: begin
        w_err   = 1'b1;
        w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_temp_poll_ctrl.sv
// Directed bench for temp_poll_ctrl with a scoreboard of expected captures.
module tb_temp_poll_ctrl;
  import temp_pkg::*;

  localparam int unsigned POLL_DIV = 10;
  localparam int unsigned TIMEOUT  = 6;
  localparam int unsigned CONFIRM  = 3;
  localparam int unsigned CNT_W    = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] data_out;
  logic        data_valid;
  logic [1:0]  zone_out;
  logic        zone_valid;
  logic        err_timeout;
  logic [7:0]  sample_cnt;

  temp_poll_ctrl_if rd();

  temp_poll_ctrl #(
    .POLL_DIV (POLL_DIV),
    .TIMEOUT  (TIMEOUT),
    .CONFIRM  (CONFIRM),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .rd          (rd),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .zone_out    (zone_out),
    .zone_valid  (zone_valid),
    .err_timeout (err_timeout),
    .sample_cnt  (sample_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  zone;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   n_err = 0;
  int   n_chk = 0;
  int   cyc = 0;
  int   dv_count = 0;
  int   rise_count = 0;
  int   last_rise = -100;
  int   period = 0;
  int   run_len = 0;
  int   req_len = 0;
  logic prev_req = 1'b0;

  logic [15:0] th_word [5] = '{16'h2000, 16'h2080, 16'h2300, 16'h2380, 16'h3F80};
  logic [1:0]  th_zone [5] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
  logic [15:0] hy_word [7] = '{16'h2080, 16'h2380, 16'h2380, 16'h2200, 16'h2380, 16'h2380, 16'h2380};
  logic [1:0]  hy_zone [7] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard pop on each data_valid pulse, plus rd_req run-length and period tracking.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && data_valid) begin
      dv_count++;
      if (q.size() == 0) begin
        chk("dv_unexpected", 32'(data_valid), 32'(0));
      end else begin
        e = q.pop_front();
        chk("sb_data", 32'(data_out), 32'(e.data));
        chk("sb_zone", 32'(zone_out), 32'(e.zone));
        chk("sb_cnt", 32'(sample_cnt), 32'(e.cnt));
        chk("sb_zvalid", 32'(zone_valid), 32'(1));
      end
    end
    if (rd.rd_req) run_len++;
    else if (prev_req) begin
      req_len = run_len;
      run_len = 0;
    end
    if (rd.rd_req && !prev_req) begin
      rise_count++;
      period    = cyc - last_rise;
      last_rise = cyc;
    end
    prev_req = rd.rd_req;
  end

  // Wait for rd_req; n is the number of falling edges waited.
  task automatic wait_req(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd.rd_req && n < 200);
    chk("req_wait", 32'(rd.rd_req), 32'(1));
    #1;
  endtask

  // Ack dly cycles after rd_req was seen, and queue the expected capture.
  task automatic serve(input int dly, input logic [15:0] word, input logic [1:0] zone,
                       input logic [7:0] cnt);
    exp_t e;
    repeat (dly) @(negedge clk);
    e.data = word;
    e.zone = zone;
    e.cnt  = cnt;
    q.push_back(e);
    rd.rd_ack  = 1'b1;
    rd.rd_data = word;
    @(negedge clk);
    rd.rd_ack = 1'b0;
    chk("req_fall", 32'(rd.rd_req), 32'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    enable    = 1'b0;
    rd.rd_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int dv0;
    int r0;
    rd.rd_ack  = 1'b0;
    rd.rd_data = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rd_req", 32'(rd.rd_req), 32'(0));
    chk("rst_data_out", 32'(data_out), 32'(0));
    chk("rst_dv", 32'(data_valid), 32'(0));
    chk("rst_zone", 32'(zone_out), 32'(0));
    chk("rst_zvalid", 32'(zone_valid), 32'(0));
    chk("rst_err", 32'(err_timeout), 32'(0));
    chk("rst_cnt", 32'(sample_cnt), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Basic poll
    enable = 1'b1;
    wait_req(n);
    chk("first_req_delay", 32'(n), 32'(10));
    dv0 = dv_count;
    serve(2, 16'h2080, 2'd1, 8'd1);
    chk("basic_req_len", 32'(req_len), 32'(3));
    chk("basic_dv_pulses", 32'(dv_count - dv0), 32'(1));
    chk("basic_hold", 32'(data_out), 32'(16'h2080));
    wait_req(n);
    chk("poll_period", 32'(period), 32'(10));

    // Threshold boundaries, each first after reset
    for (int i = 0; i < 5; i++) begin
      do_reset();
      enable = 1'b1;
      wait_req(n);
      serve(1, th_word[i], th_zone[i], 8'd1);
    end

    // Filter hysteresis
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_req(n);
      serve(1, hy_word[i], hy_zone[i], 8'(i + 1));
    end
    chk("hyst_final_zone", 32'(zone_out), 32'(2));

    // Timeout
    dv0 = dv_count;
    wait_req(n);
    repeat (8) @(negedge clk);
    chk("to_req_len", 32'(req_len), 32'(6));
    chk("to_req_low", 32'(rd.rd_req), 32'(0));
    chk("to_err", 32'(err_timeout), 32'(1));
    chk("to_data_hold", 32'(data_out), 32'(16'h2380));
    chk("to_cnt_hold", 32'(sample_cnt), 32'(7));
    chk("to_no_dv", 32'(dv_count - dv0), 32'(0));
    wait_req(n);
    serve(1, 16'h2100, 2'd2, 8'd8);
    chk("to_err_clear", 32'(err_timeout), 32'(0));
    chk("to_recover_data", 32'(data_out), 32'(16'h2100));

    // Reset mid-REQ with a late ack
    wait_req(n);
    #2;
    rst_n      = 1'b0;
    rd.rd_ack  = 1'b1;
    rd.rd_data = 16'h3F80;
    #1;
    chk("mid_rst_req", 32'(rd.rd_req), 32'(0));
    chk("mid_rst_data", 32'(data_out), 32'(0));
    chk("mid_rst_zvalid", 32'(zone_valid), 32'(0));
    chk("mid_rst_cnt", 32'(sample_cnt), 32'(0));
    chk("mid_rst_err", 32'(err_timeout), 32'(0));
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dv0 = dv_count;
    repeat (2) @(negedge clk);
    chk("late_ack_req", 32'(rd.rd_req), 32'(0));
    chk("late_ack_dv", 32'(dv_count - dv0), 32'(0));
    chk("late_ack_zvalid", 32'(zone_valid), 32'(0));
    rd.rd_ack = 1'b0;
    enable    = 1'b1;
    wait_req(n);
    chk("post_rst_req_delay", 32'(n), 32'(10));
    serve(1, 16'h2000, 2'd0, 8'd1);

    // Enable drop mid-transaction
    wait_req(n);
    enable = 1'b0;
    dv0 = dv_count;
    serve(1, 16'h2380, 2'd0, 8'd2);
    r0 = rise_count;
    repeat (30) @(negedge clk);
    chk("drop_no_req", 32'(rise_count - r0), 32'(0));
    chk("drop_one_dv", 32'(dv_count - dv0), 32'(1));
    chk("drop_zone", 32'(zone_out), 32'(0));

    chk("sb_empty", 32'(q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
